// File: rtl/ysyx_25040105_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, bus response code
// and the controller state set.
package ysyx_25040105_lsu_pkg;

    localparam logic [1:0] SZ_B    = 2'd0;
    localparam logic [1:0] SZ_H    = 2'd1;
    localparam logic [1:0] SZ_W    = 2'd2;

    localparam logic [1:0] RESP_OK = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_DONE
    } lsu_state_e;

endpackage

// File: rtl/ysyx_25040105_lsu_align.sv
// Byte-lane steering for the LSU: alignment check, store lane shift and
// strobes, load lane extraction with sign/zero extension. Purely combinational.
module ysyx_25040105_lsu_align
    import ysyx_25040105_lsu_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic        misaligned_o,
    output logic [31:0] st_data_o,
    output logic [3:0]  st_strb_o,
    output logic [31:0] ld_data_o
);

    logic [4:0]  shamt;
    logic [31:0] lane;

    assign shamt     = {off_i, 3'b000};
    assign st_data_o = st_data_i << shamt;
    assign lane      = ld_word_i >> shamt;

    // Natural alignment per size; the reserved size never reaches the bus.
    always_comb begin
        misaligned_o = 1'b1;
        case (size_i)
            SZ_B:    misaligned_o = 1'b0;
            SZ_H:    misaligned_o = off_i[0];
            SZ_W:    misaligned_o = |off_i;
            default: misaligned_o = 1'b1;
        endcase
    end

    // Byte enables follow the access width shifted to the addressed lane.
    always_comb begin
        st_strb_o = 4'b1111;
        case (size_i)
            SZ_B:    st_strb_o = 4'b0001 << off_i;
            SZ_H:    st_strb_o = 4'b0011 << off_i;
            default: st_strb_o = 4'b1111;
        endcase
    end

    // Pick the addressed lane and extend it to a full register value.
    always_comb begin
        ld_data_o = ld_word_i;
        case (size_i)
            SZ_B:    ld_data_o = {{24{signed_i & lane[7]}}, lane[7:0]};
            SZ_H:    ld_data_o = {{16{signed_i & lane[15]}}, lane[15:0]};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/ysyx_25040105_lsu.sv
// Load/store unit: takes one request from the EXU, runs it on a split
// read/write bus with valid/ready handshakes and returns a one-cycle response.
module ysyx_25040105_lsu
    import ysyx_25040105_lsu_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter logic [1:0] RESP_OK = 2'b00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [31:0]       wdata_q;
    logic              aw_done_q, w_done_q;
    logic [31:0]       result_q;
    logic              err_q;

    logic              in_idle;
    logic [1:0]        al_off, al_size;
    logic              misaligned;
    logic [31:0]       ld_data;

    // While idle the checker looks at the incoming request; afterwards it
    // works on the latched copy so bus-side outputs stay stable.
    assign in_idle = (state_q == S_IDLE);
    assign al_off  = in_idle ? req_addr[1:0] : addr_q[1:0];
    assign al_size = in_idle ? req_size      : size_q;

    ysyx_25040105_lsu_align u_align (
        .off_i        (al_off),
        .size_i       (al_size),
        .signed_i     (signed_q),
        .st_data_i    (wdata_q),
        .ld_word_i    (rdata),
        .misaligned_o (misaligned),
        .st_data_o    (wdata),
        .st_strb_o    (wstrb),
        .ld_data_o    (ld_data)
    );

    assign araddr    = {addr_q[ADDR_W-1:2], 2'b00};
    assign awaddr    = {addr_q[ADDR_W-1:2], 2'b00};
    assign rsp_rdata = (state_q == S_DONE) ? result_q : 32'd0;
    assign rsp_err   = (state_q == S_DONE) & err_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs, all decoded from registered state.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (misaligned)   state_d = S_DONE;
                    else if (req_wen) state_d = S_WR_REQ;
                    else              state_d = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) state_d = S_DONE;
            end
            S_WR_REQ: begin
                awvalid = ~aw_done_q;
                wvalid  = ~w_done_q;
                if ((aw_done_q | awready) && (w_done_q | wready)) state_d = S_WR_RESP;
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) state_d = S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, per-channel write flags and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            size_q    <= 2'd0;
            signed_q  <= 1'b0;
            wdata_q   <= 32'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            result_q  <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        wdata_q   <= req_wdata;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        result_q  <= 32'd0;
                        err_q     <= misaligned;
                    end
                end
                S_RD_DATA: begin
                    if (rvalid) begin
                        err_q    <= (rresp != RESP_OK);
                        result_q <= (rresp == RESP_OK) ? ld_data : 32'd0;
                    end
                end
                S_WR_REQ: begin
                    if (awvalid && awready) aw_done_q <= 1'b1;
                    if (wvalid && wready)   w_done_q  <= 1'b1;
                end
                S_WR_RESP: begin
                    if (bvalid) err_q <= (bresp != RESP_OK);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040105_lsu.sv
// Self-checking bench for the LSU: directed scenarios plus randomized
// transactions against a spec-level reference model and a delaying bus slave.
module tb_ysyx_25040105_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25040105_lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        int          rsp_count;
        int          lat;
        logic [31:0] rsp_rdata;
        logic        rsp_err;
        logic        ready_after;
        int          n_ar, n_r, n_aw, n_w, n_b;
        logic [31:0] araddr, awaddr, wdata;
        logic [3:0]  wstrb;
        int          viol;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] sz);
        int nbytes;
        if (sz == 2'd3) return 1'b1;
        nbytes = 1 << sz;
        return (a % nbytes) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sgn);
        int          bits;
        longint      m;
        logic [31:0] mask, v;
        if (sz == 2'd2) return rd;
        bits = 8 << sz;
        m    = (longint'(1) << bits) - 1;
        mask = m[31:0];
        v    = (rd >> (8 * (a % 4))) & mask;
        if (sgn && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [31:0] a, input logic [1:0] sz);
        int s;
        s = ((1 << (1 << sz)) - 1) << (a % 4);
        return s[3:0];
    endfunction

    // ---------------- driver + bus slave ----------------
    // Presents one request, then plays the slave with per-channel ready /
    // response delays and reports what it observed.
    task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] wd, input logic [31:0] rd,
                           input logic [1:0] resp, input int ar_d, input int r_d,
                           input int aw_d, input int w_d, input int b_d, output obs_t o);
        int ar_c, r_c, aw_c, w_c, b_c, cyc;
        bit ar_ok, r_ok, aw_ok, w_ok, b_ok;
        bit ar_f, r_f, aw_f, w_f, b_f;
        bit ar_p, aw_p, w_p;
        logic [31:0] ar_prev, aw_prev, w_prev;
        logic [3:0]  s_prev;
        o = '{default: 0};
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        ar_ok = 0; r_ok = 0; aw_ok = 0; w_ok = 0; b_ok = 0;
        ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0;
        ar_p = 0; aw_p = 0; w_p = 0;
        ar_prev = 0; aw_prev = 0; w_prev = 0; s_prev = 0;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (cyc <= 60) begin
            if (ar_f) begin ar_ok = 1; o.n_ar++; end
            if (r_f)  begin r_ok  = 1; o.n_r++;  end
            if (aw_f) begin aw_ok = 1; o.n_aw++; end
            if (w_f)  begin w_ok  = 1; o.n_w++;  end
            if (b_f)  begin b_ok  = 1; o.n_b++;  end
            if (rsp_valid) begin
                o.rsp_count++;
                if (o.rsp_count == 1) begin
                    o.lat = cyc; o.rsp_rdata = rsp_rdata; o.rsp_err = rsp_err;
                end
            end
            if (o.rsp_count > 0 && cyc == o.lat + 1) o.ready_after = req_ready;
            if (ar_p && (!arvalid || araddr !== ar_prev)) o.viol++;
            if (aw_p && (!awvalid || awaddr !== aw_prev)) o.viol++;
            if (w_p && (!wvalid || wdata !== w_prev || wstrb !== s_prev)) o.viol++;
            if ((arvalid && ar_ok) || (awvalid && aw_ok) || (wvalid && w_ok)) o.viol++;
            if (arvalid) o.araddr = araddr;
            if (awvalid) o.awaddr = awaddr;
            if (wvalid) begin o.wdata = wdata; o.wstrb = wstrb; end
            arready = arvalid && (ar_c >= ar_d);
            if (arvalid) ar_c++;
            rvalid = ar_ok && !r_ok && (r_c >= r_d);
            rdata  = rd; rresp = resp;
            if (ar_ok && !r_ok) r_c++;
            awready = awvalid && (aw_c >= aw_d);
            if (awvalid) aw_c++;
            wready = wvalid && (w_c >= w_d);
            if (wvalid) w_c++;
            bvalid = aw_ok && w_ok && !b_ok && (b_c >= b_d);
            bresp  = resp;
            if (aw_ok && w_ok && !b_ok) b_c++;
            ar_f = arvalid && arready; r_f = rvalid && rready;
            aw_f = awvalid && awready; w_f = wvalid && wready; b_f = bvalid && bready;
            ar_p = arvalid && !arready; ar_prev = araddr;
            aw_p = awvalid && !awready; aw_prev = awaddr;
            w_p = wvalid && !wready; w_prev = wdata; s_prev = wstrb;
            if (o.rsp_count > 0 && cyc >= o.lat + 2) break;
            @(negedge clk);
            cyc++;
        end
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 10000000",
                     {req_ready, arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err});
        end
        checks++;
        if (rsp_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_rdata got %h want 00000000", rsp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_idle_ready got %b want 1", req_ready);
        end
        $display("reset: ready=%b rsp_valid=%b", req_ready, rsp_valid);
    endtask

    task automatic test_load_byte_signed();
        obs_t o;
        run_txn(1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'd0, 32'h80FF_1234, 2'b00, 0, 0, 0, 0, 0, o);
        $display("lb  addr=80000003 rdata=%h err=%b lat=%0d", o.rsp_rdata, o.rsp_err, o.lat);
        checks++;
        if (o.araddr !== 32'h8000_0000) begin errors++; $display("FAIL lb_araddr got %h want 80000000", o.araddr); end
        checks++;
        if (o.rsp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got %h want ffffff80", o.rsp_rdata); end
        checks++;
        if (o.rsp_err !== 1'b0) begin errors++; $display("FAIL lb_err got %b want 0", o.rsp_err); end
        checks++;
        if (o.lat != 3 || o.rsp_count != 1) begin
            errors++; $display("FAIL lb_latency got lat %0d count %0d want lat 3 count 1", o.lat, o.rsp_count);
        end
    endtask

    task automatic test_load_half_unsigned();
        obs_t o;
        run_txn(1'b0, 32'h8000_0002, 2'd1, 1'b0, 32'd0, 32'hBEEF_0000, 2'b00, 0, 0, 0, 0, 0, o);
        $display("lhu addr=80000002 rdata=%h err=%b lat=%0d", o.rsp_rdata, o.rsp_err, o.lat);
        checks++;
        if (o.rsp_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_rdata got %h want 0000beef", o.rsp_rdata); end
        checks++;
        if (o.rsp_err !== 1'b0 || o.rsp_count != 1) begin
            errors++; $display("FAIL lhu_rsp got err %b count %0d want err 0 count 1", o.rsp_err, o.rsp_count);
        end
    endtask

    task automatic test_store_half();
        obs_t o;
        run_txn(1'b1, 32'h8000_0102, 2'd1, 1'b0, 32'h0000_ABCD, 32'd0, 2'b00, 0, 0, 0, 2, 0, o);
        $display("sh  addr=80000102 awaddr=%h wdata=%h wstrb=%b lat=%0d", o.awaddr, o.wdata, o.wstrb, o.lat);
        checks++;
        if (o.awaddr !== 32'h8000_0100) begin errors++; $display("FAIL sh_awaddr got %h want 80000100", o.awaddr); end
        checks++;
        if (o.wdata !== 32'hABCD_0000) begin errors++; $display("FAIL sh_wdata got %h want abcd0000", o.wdata); end
        checks++;
        if (o.wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got %b want 1100", o.wstrb); end
        checks++;
        if (o.rsp_count != 1 || o.lat != 5 || o.n_b != 1) begin
            errors++; $display("FAIL sh_rsp got count %0d lat %0d b %0d want 1 5 1", o.rsp_count, o.lat, o.n_b);
        end
        checks++;
        if (o.viol != 0 || o.n_aw != 1 || o.n_w != 1) begin
            errors++; $display("FAIL sh_proto got viol %0d aw %0d w %0d want 0 1 1", o.viol, o.n_aw, o.n_w);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_txn(1'b0, 32'h8000_0001, 2'd2, 1'b0, 32'd0, 32'h1111_1111, 2'b00, 0, 0, 0, 0, 0, o);
        $display("lw  addr=80000001 err=%b rdata=%h lat=%0d", o.rsp_err, o.rsp_rdata, o.lat);
        checks++;
        if (o.n_ar != 0 || o.n_aw != 0) begin errors++; $display("FAIL mis_bus got ar %0d aw %0d want 0 0", o.n_ar, o.n_aw); end
        checks++;
        if (o.lat != 1 || o.rsp_count != 1) begin
            errors++; $display("FAIL mis_latency got lat %0d count %0d want 1 1", o.lat, o.rsp_count);
        end
        checks++;
        if (o.rsp_err !== 1'b1 || o.rsp_rdata !== 32'd0) begin
            errors++; $display("FAIL mis_rsp got err %b rdata %h want 1 00000000", o.rsp_err, o.rsp_rdata);
        end
    endtask

    task automatic test_bus_error();
        obs_t o;
        run_txn(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'd0, 32'hCAFE_F00D, 2'b10, 0, 0, 0, 0, 0, o);
        $display("lw  addr=80000004 rresp=10 err=%b rdata=%h", o.rsp_err, o.rsp_rdata);
        checks++;
        if (o.rsp_err !== 1'b1 || o.rsp_rdata !== 32'd0) begin
            errors++; $display("FAIL buserr_rsp got err %b rdata %h want 1 00000000", o.rsp_err, o.rsp_rdata);
        end
        run_txn(1'b0, 32'h8000_0008, 2'd2, 1'b0, 32'd0, 32'h1234_5678, 2'b00, 0, 0, 0, 0, 0, o);
        $display("lw  addr=80000008 err=%b rdata=%h lat=%0d", o.rsp_err, o.rsp_rdata, o.lat);
        checks++;
        if (o.rsp_err !== 1'b0 || o.rsp_rdata !== 32'h1234_5678 || o.lat != 3) begin
            errors++;
            $display("FAIL buserr_next got err %b rdata %h lat %0d want 0 12345678 3", o.rsp_err, o.rsp_rdata, o.lat);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_size = 2'd2;
        req_signed = 1'b0; req_wdata = 32'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        checks++;
        if (rready !== 1'b1) begin errors++; $display("FAIL rstmid_in_rdata got rready %b want 1", rready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, rsp_valid, req_ready} !== 7'b000_0001) begin
            errors++;
            $display("FAIL rstmid_ctrl got %b want 0000001", {arvalid, rready, awvalid, wvalid, bready, rsp_valid, req_ready});
        end
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL rstmid_no_rsp got %0d pulses want 0", pulses); end
        $display("reset mid-read: rsp pulses=%0d ready=%b", pulses, req_ready);
    endtask

    task automatic test_random();
        obs_t o;
        logic wen, sgn;
        logic [31:0] a, wd, rd, exp_rdata;
        logic [1:0] sz, resp;
        int ar_d, r_d, aw_d, w_d, b_d, exp_lat;
        bit mis, exp_err;
        for (int i = 0; i < 60; i++) begin
            wen = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            a   = 32'h8000_0000 + $urandom_range(0, 255);
            sz  = 2'($urandom_range(0, 3));
            wd  = $urandom;
            rd  = $urandom;
            resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, 3);
            aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_d = $urandom_range(0, 3);
            run_txn(wen, a, sz, sgn, wd, rd, resp, ar_d, r_d, aw_d, w_d, b_d, o);
            mis       = ref_misaligned(a, sz);
            exp_err   = mis || (resp != 2'b00);
            exp_rdata = (exp_err || wen) ? 32'd0 : ref_load(rd, a, sz, sgn);
            if (mis)      exp_lat = 1;
            else if (wen) exp_lat = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
            else          exp_lat = 3 + ar_d + r_d;
            $display("rnd %0d wen=%b addr=%h sz=%0d sgn=%b resp=%b -> rdata=%h err=%b lat=%0d",
                     i, wen, a, sz, sgn, resp, o.rsp_rdata, o.rsp_err, o.lat);
            checks++;
            if (o.rsp_count != 1 || o.lat != exp_lat) begin
                errors++; $display("FAIL rnd%0d_timing got count %0d lat %0d want 1 %0d", i, o.rsp_count, o.lat, exp_lat);
            end
            checks++;
            if (o.rsp_err !== exp_err || o.rsp_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rnd%0d_rsp got err %b rdata %h want %b %h", i, o.rsp_err, o.rsp_rdata, exp_err, exp_rdata);
            end
            checks++;
            if (o.ready_after !== 1'b1 || o.viol != 0) begin
                errors++; $display("FAIL rnd%0d_proto got ready %b viol %0d want 1 0", i, o.ready_after, o.viol);
            end
            checks++;
            if (o.n_ar != ((!mis && !wen) ? 1 : 0) || o.n_aw != ((!mis && wen) ? 1 : 0)
                || o.n_w != ((!mis && wen) ? 1 : 0)) begin
                errors++; $display("FAIL rnd%0d_bus got ar %0d aw %0d w %0d", i, o.n_ar, o.n_aw, o.n_w);
            end
            if (!mis && !wen) begin
                checks++;
                if (o.araddr !== (a & ~32'd3)) begin
                    errors++; $display("FAIL rnd%0d_araddr got %h want %h", i, o.araddr, a & ~32'd3);
                end
            end
            if (!mis && wen) begin
                checks++;
                if (o.awaddr !== (a & ~32'd3) || o.wdata !== (wd << (8 * (a % 4))) || o.wstrb !== ref_strb(a, sz)) begin
                    errors++;
                    $display("FAIL rnd%0d_store got %h %h %b want %h %h %b", i, o.awaddr, o.wdata, o.wstrb,
                             a & ~32'd3, wd << (8 * (a % 4)), ref_strb(a, sz));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_wen = 0; req_addr = 0; req_size = 0; req_signed = 0; req_wdata = 0;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        @(negedge clk);
        test_reset();
        test_load_byte_signed();
        test_load_half_unsigned();
        test_store_half();
        test_misaligned();
        test_bus_error();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25040105_lsu.md
Name: ysyx_25040105_lsu

Overview:
Load/store unit sitting directly downstream of the EXU. It accepts one memory request per transaction (address, size, store data) and runs it on an AXI4-Lite-style split read/write bus. It returns the aligned, sign- or zero-extended load result, or store completion, to the register-file writeback path. This block replaces the single-cycle direct memory access with a multi-cycle handshake; the core stalls while rsp_valid is pending.

Parameters:
ADDR_W, 32, request/bus address width
RESP_OK, 2'b00, bus response code treated as success; any other value is an error

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  1  EXU presents a memory request
req_ready  out  1  LSU can accept; high only in IDLE
req_wen  in  1  1=store, 0=load
req_addr  in  ADDR_W  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend
req_wdata  in  32  store data, LSB-justified
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  32  extended load result; 0 for stores and errors
rsp_err  out  1  misaligned access or bus error; valid with rsp_valid
araddr  out  ADDR_W  read address (word-aligned: low 2 bits forced 0)
arvalid  out  1  read address valid
arready  in  1  read address accepted
rdata  in  32  read word, byte lane n = bits [8n+7:8n]
rresp  in  2  read response
rvalid  in  1  read data valid
rready  out  1  LSU accepts read data
awaddr  out  ADDR_W  write address (word-aligned)
awvalid  out  1  write address valid
awready  in  1  write address accepted
wdata  out  32  store data shifted into lanes
wstrb  out  4  byte enables
wvalid  out  1  write data valid
wready  in  1  write data accepted
bresp  in  2  write response
bvalid  in  1  write response valid
bready  out  1  LSU accepts write response

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Reset (rst high at posedge): state=IDLE. arvalid, rready, awvalid, wvalid, bready, rsp_valid and rsp_err are 0; rsp_rdata=0. Internal latches are cleared. Reset mid-transaction abandons the transaction; no rsp_valid is produced for it.
- IDLE: req_ready=1. On req_valid, latch addr, size, signed, wen, wdata.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size=3): go to DONE with err=1. No bus traffic.
  - Load: go to RD_ADDR.
  - Store: go to WR_REQ.
- RD_ADDR: arvalid=1 and araddr stable until arready; then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, then go to DONE.
- WR_REQ: awvalid and wvalid are both raised on entry. Each drops the cycle after its own handshake (per-channel done flags). When both are done, go to WR_RESP. The two handshakes may occur in the same or in different cycles.
- WR_RESP: bready=1. On bvalid, capture bresp, then go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then return to IDLE. The next request is accepted no earlier than the cycle after DONE.
- Latency with zero-wait slave: load request accepted at cycle T, arvalid at T+1, rvalid at T+2, rsp_valid at T+3. Store follows the same timing: aw/w at T+1, bvalid at T+2, rsp at T+3. Misaligned: rsp at T+1.
- Load extract: off=addr[1:0]; lane=rdata>>(8*off). Byte uses lane[7:0]; half uses lane[15:0]. Extend to 32 bits per req_signed. Word uses the full value.
- Store lanes: wdata=req_wdata<<(8*off). wstrb is 4'b0001<<off for byte, 4'b0011<<off for half, 4'b1111 for word.
- rresp or bresp != RESP_OK: rsp_err=1, rsp_rdata=0.
- AXI rule: once asserted, valids hold until handshake; address and data stay stable.

Decomposition:
- Package ysyx_25040105_lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), FSM state enum, RESP_OK constant.
- Sub-module ysyx_25040105_lsu_align (combinational): misalign check, wstrb/wdata lane shift, load extract and extend. Instantiated once.

Test Plan:
- Load byte signed: addr=0x8000_0003, rdata=0x80FF_1234 -> araddr=0x8000_0000, rsp_rdata=0xFFFF_FF80, rsp_err=0, rsp_valid at T+3.
- Load half unsigned: addr=0x8000_0002, rdata=0xBEEF_0000 -> rsp_rdata=0x0000_BEEF.
- Store half: addr=0x8000_0102, wdata=0x0000_ABCD -> awaddr=0x8000_0100, wdata=0xABCD_0000, wstrb=4'b1100. Slave takes aw at T+1, w at T+3 -> rsp_valid once, after bvalid.
- Misaligned word load: addr=0x8000_0001 -> no arvalid ever, rsp_valid at T+1 with rsp_err=1, rsp_rdata=0.
- Bus error: word load with rresp=2'b10 -> rsp_err=1, rsp_rdata=0. Next request accepted normally.
- Reset during RD_DATA (rvalid withheld): rst=1 for one cycle -> all valids and rready 0 the next cycle, rsp_valid never pulses, req_ready=1.
